// File: rtl/host_mem_pkg.sv
// Shared types and widths for the host memory sequencer.
package host_mem_pkg;

  localparam int unsigned ADR_W  = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [2:0] {
    OP_WR_I = 3'd0,
    OP_WR_D = 3'd1,
    OP_RD_I = 3'd2,
    OP_RD_D = 3'd3,
    OP_RUN  = 3'd4,
    OP_QUIT = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdWait,
    StRdRsp,
    StStart,
    StQuit
  } state_e;

endpackage

// File: rtl/host_mem_sched_if.sv
// Host command/response channel between the UART monitor and the sequencer.
interface host_mem_sched_if;
  import host_mem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADR_W-1:0]  cmd_adr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, cmd_err
  );

endinterface

// File: rtl/host_mem_rdpipe.sv
// Read-latency delay line plus the response register with valid/ready hold.
module host_mem_rdpipe
  import host_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rsp_ready,
  output logic              capture,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  logic [RD_LAT-1:0] pipe_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  // Issue bit reaches the top of the line in the cycle rdata becomes valid.
  assign capture = pipe_q[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      pipe_q <= RD_LAT'({pipe_q, issue});
      if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= rdata;
      end else if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/host_mem_sched.sv
// Host-side sequencer driving the core's RAM load/dump ports and run/quit controls.
// Optional run watchdog enabled by defining RUN_WDOG_EN.
module host_mem_sched
  import host_mem_pkg::*;
#(
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  host_mem_sched_if.slave   host,
  output logic              running,
  output logic [ADR_W-1:0]  i_ram_wadr,
  output logic [DATA_W-1:0] i_ram_wdata,
  output logic              i_ram_wen,
  output logic [ADR_W-1:0]  i_ram_radr,
  output logic              i_read_sel,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [ADR_W-1:0]  d_ram_wadr,
  output logic [DATA_W-1:0] d_ram_wdata,
  output logic              d_ram_wen,
  output logic [ADR_W-1:0]  d_ram_radr,
  output logic              d_read_sel,
  input  logic [DATA_W-1:0] d_ram_rdata,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic [29:0]       start_adr
);

  state_e            state_q, state_d;
  logic              is_i_q, is_i_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [29:0]       start_adr_q, start_adr_d;
  logic              running_q, running_d;
  logic              err_q, err_d;
  logic              alive_q;

  cmd_op_e           op;
  logic              accept, rd_phase, capture, rsp_valid;
  logic [DATA_W-1:0] rd_mux;
  logic              wdog_fire, wdog_pend;

  assign op     = cmd_op_e'(host.cmd_op);
  assign accept = host.cmd_valid && host.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      is_i_q      <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      start_adr_q <= '0;
      running_q   <= 1'b0;
      err_q       <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_i_q      <= is_i_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      start_adr_q <= start_adr_d;
      running_q   <= running_d;
      err_q       <= err_d;
      alive_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_i_d      = is_i_q;
    adr_d       = adr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    start_adr_d = start_adr_q;
    running_d   = running_q;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // While the core runs only QUIT gets through; everything else is rejected.
          if (wdog_pend || (running_q && op != OP_QUIT)) begin
            err_d = 1'b1;
          end else begin
            adr_d  = host.cmd_adr;
            data_d = host.cmd_data;
            cnt_d  = host.cmd_len;
            is_i_d = (op == OP_WR_I) || (op == OP_RD_I);
            case (op)
              OP_WR_I, OP_WR_D: state_d = StWr;
              OP_RD_I, OP_RD_D: state_d = StRdIssue;
              OP_RUN:           state_d = StStart;
              OP_QUIT:          state_d = StQuit;
              default:          err_d   = 1'b1;
            endcase
          end
        end
      end
      StWr:      state_d = StIdle;
      StRdIssue: state_d = StRdWait;
      StRdWait:  if (capture) state_d = StRdRsp;
      StRdRsp: begin
        if (rsp_valid && host.rsp_ready) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            adr_d   = adr_q + ADR_W'(1);
            state_d = StRdIssue;
          end
        end
      end
      StStart: begin
        start_adr_d = data_q[31:2];
        running_d   = 1'b1;
        state_d     = StIdle;
      end
      StQuit: begin
        running_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (wdog_fire) running_d = 1'b0;
  end

`ifdef RUN_WDOG_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_pend_q, wdog_pend_d, host_quit;

  assign host_quit = (state_q == StQuit) || (accept && op == OP_QUIT);
  assign wdog_fire = running_q && !host_quit && (wdog_cnt_q == WdogW'(TIMEOUT - 1));

  always_comb begin
    wdog_cnt_d  = (running_q && !host_quit) ? wdog_cnt_q + WdogW'(1) : '0;
    wdog_pend_d = wdog_pend_q;
    if (accept)         wdog_pend_d = 1'b0;
    else if (wdog_fire) wdog_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q  <= '0;
      wdog_pend_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_pend_q <= wdog_pend_d;
    end
  end

  assign wdog_pend = wdog_pend_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign wdog_fire      = 1'b0;
  assign wdog_pend      = 1'b0;
`endif

  assign rd_mux = is_i_q ? i_ram_rdata : d_ram_rdata;

  host_mem_rdpipe #(
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .issue     (state_q == StRdIssue),
    .rdata     (rd_mux),
    .rsp_ready (host.rsp_ready),
    .capture   (capture),
    .rsp_valid (rsp_valid),
    .rsp_data  (host.rsp_data)
  );

  assign rd_phase = (state_q == StRdIssue) || (state_q == StRdWait) || (state_q == StRdRsp);

  assign host.cmd_ready = alive_q && (state_q == StIdle);
  assign host.rsp_valid = rsp_valid;
  assign host.cmd_err   = err_q;

  // RAM pins are forced to zero whenever their port is not in use.
  assign i_ram_wen   = (state_q == StWr) && is_i_q;
  assign d_ram_wen   = (state_q == StWr) && !is_i_q;
  assign i_read_sel  = rd_phase && is_i_q;
  assign d_read_sel  = rd_phase && !is_i_q;
  assign i_ram_wadr  = i_ram_wen ? adr_q : '0;
  assign i_ram_wdata = i_ram_wen ? data_q : '0;
  assign d_ram_wadr  = d_ram_wen ? adr_q : '0;
  assign d_ram_wdata = d_ram_wen ? data_q : '0;
  assign i_ram_radr  = i_read_sel ? adr_q : '0;
  assign d_ram_radr  = d_read_sel ? adr_q : '0;

  assign cpu_start = (state_q == StStart);
  assign quit_cmd  = (state_q == StQuit) || wdog_fire;
  assign running   = running_q;
  assign start_adr = start_adr_q;

endmodule

// File: tb/tb_host_mem_sched.sv
// Directed bench for host_mem_sched with a 1-cycle-latency RAM read model.
module tb_host_mem_sched;
  import host_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running, cpu_start, quit_cmd;
  logic [11:0] i_wadr, i_radr, d_wadr, d_radr;
  logic [31:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic        i_wen, d_wen, i_sel, d_sel;
  logic [29:0] start_adr;
  int          n_checks = 0;
  int          n_fail = 0;

  host_mem_sched_if bus ();

  host_mem_sched #(
    .RD_LAT  (1),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .running     (running),
    .i_ram_wadr  (i_wadr),
    .i_ram_wdata (i_wdata),
    .i_ram_wen   (i_wen),
    .i_ram_radr  (i_radr),
    .i_read_sel  (i_sel),
    .i_ram_rdata (i_rdata),
    .d_ram_wadr  (d_wadr),
    .d_ram_wdata (d_wdata),
    .d_ram_wen   (d_wen),
    .d_ram_radr  (d_radr),
    .d_read_sel  (d_sel),
    .d_ram_rdata (d_rdata),
    .cpu_start   (cpu_start),
    .quit_cmd    (quit_cmd),
    .start_adr   (start_adr)
  );

  always #5 clk = ~clk;

  // RAM read model: registered, word value tagged by RAM and address.
  always @(posedge clk) begin
    i_rdata <= 32'hC0DE_0000 | {20'h0, i_radr};
    d_rdata <= 32'hDA7A_0000 | {20'h0, d_radr};
  end

  logic any_out;
  assign any_out = |{bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.cmd_err, running, i_wadr,
                     i_wdata, i_wen, i_radr, i_sel, d_wadr, d_wdata, d_wen, d_radr, d_sel,
                     cpu_start, quit_cmd, start_adr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] adr, input logic [7:0] len,
                      input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_adr   = adr;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
  endtask

  task automatic test_reset;
    tick;
    n_checks++;
    if (any_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", any_out);
    end
    rst = 1'b0;
    tick;
    tick;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_i;
    send(3'd0, 12'h010, 8'd0, 32'hDEADBEEF);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({i_wen, i_wadr, i_wdata, bus.cmd_ready, d_wen, i_sel} !== {1'b1, 12'h010, 32'hDEADBEEF, 3'b000})
    begin
      n_fail++; $display("FAIL wr_i_cycle: got %b/%h/%h rdy=%b dwen=%b sel=%b want 1/010/deadbeef 0 0 0",
                         i_wen, i_wadr, i_wdata, bus.cmd_ready, d_wen, i_sel);
    end
    tick;
    n_checks++;
    if ({i_wen, i_wadr, i_wdata, bus.cmd_ready} !== {1'b0, 12'h000, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL wr_i_after: got wen=%b adr=%h data=%h rdy=%b want 0/000/0/1",
                         i_wen, i_wadr, i_wdata, bus.cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    send(3'd1, 12'h100, 8'd0, 32'h1111_0001);
    tick;
    n_checks++;
    if ({d_wen, d_wadr, bus.cmd_ready} !== {1'b1, 12'h100, 1'b0}) begin
      n_fail++; $display("FAIL b2b_first: got wen=%b adr=%h rdy=%b want 1/100/0", d_wen, d_wadr,
                         bus.cmd_ready);
    end
    send(3'd1, 12'h101, 8'd0, 32'h2222_0002);
    tick;
    n_checks++;
    if ({d_wen, bus.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gap: got wen=%b rdy=%b want 0/1", d_wen, bus.cmd_ready);
    end
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({d_wen, d_wadr, d_wdata} !== {1'b1, 12'h101, 32'h2222_0002}) begin
      n_fail++; $display("FAIL b2b_second: got wen=%b adr=%h data=%h want 1/101/22220002", d_wen,
                         d_wadr, d_wdata);
    end
    tick;
  endtask

  task automatic test_rd_burst_d;
    int got = 0;
    int cyc = 0;
    logic [31:0] exp_w;
    send(3'd3, 12'h020, 8'd3, 32'h0);
    bus.rsp_ready = 1'b0;
    tick;
    bus.cmd_valid = 1'b0;
    while (got < 4 && cyc < 200) begin
      bus.rsp_ready = cyc[0];
      n_checks++;
      if ({d_sel, i_sel, d_wen} !== 3'b100) begin
        n_fail++; $display("FAIL rd_d_sel: cycle %0d got dsel=%b isel=%b dwen=%b want 1/0/0", cyc,
                           d_sel, i_sel, d_wen);
      end
      if (bus.rsp_valid) begin
        exp_w = 32'hDA7A_0000 | {20'h0, 12'h020 + 12'(got)};
        n_checks++;
        if (bus.rsp_data !== exp_w) begin
          n_fail++; $display("FAIL rd_d_data: word %0d got %h want %h", got, bus.rsp_data, exp_w);
        end
        if (bus.rsp_ready) got++;
      end
      tick;
      cyc++;
    end
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL rd_d_count: got %0d words want 4", got);
    end
    n_checks++;
    if ({d_sel, bus.rsp_valid, bus.cmd_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rd_d_end: got sel=%b vld=%b rdy=%b want 0/0/1", d_sel,
                         bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_rd_wrap_i;
    logic [11:0] seen[$];
    logic [31:0] words[$];
    int cyc = 0;
    send(3'd2, 12'hFFE, 8'd2, 32'h0);
    bus.rsp_ready = 1'b1;
    tick;
    bus.cmd_valid = 1'b0;
    while (words.size() < 3 && cyc < 100) begin
      if (i_sel && (seen.size() == 0 || seen[$] != i_radr)) seen.push_back(i_radr);
      if (bus.rsp_valid) words.push_back(bus.rsp_data);
      tick;
      cyc++;
    end
    n_checks++;
    if (seen.size() != 3 || seen[0] !== 12'hFFE || seen[1] !== 12'hFFF || seen[2] !== 12'h000)
    begin
      n_fail++; $display("FAIL rd_i_radr_seq: got %p want FFE FFF 000", seen);
    end
    n_checks++;
    if (words.size() != 3 || words[0] !== 32'hC0DE_0FFE || words[1] !== 32'hC0DE_0FFF ||
        words[2] !== 32'hC0DE_0000) begin
      n_fail++; $display("FAIL rd_i_words: got %p want c0de0ffe c0de0fff c0de0000", words);
    end
  endtask

  task automatic test_run_quit;
    send(3'd4, 12'h0, 8'd0, 32'h0000_0100);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({cpu_start, bus.cmd_ready} !== 2'b10) begin
      n_fail++; $display("FAIL run_start: got start=%b rdy=%b want 1/0", cpu_start, bus.cmd_ready);
    end
    tick;
    n_checks++;
    if ({cpu_start, running, start_adr} !== {1'b0, 1'b1, 30'h40}) begin
      n_fail++; $display("FAIL run_state: got start=%b run=%b adr=%h want 0/1/40", cpu_start,
                         running, start_adr);
    end
    send(3'd1, 12'h033, 8'd0, 32'h5555_5555);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({bus.cmd_err, d_wen, bus.cmd_ready} !== 3'b101) begin
      n_fail++; $display("FAIL run_reject: got err=%b dwen=%b rdy=%b want 1/0/1", bus.cmd_err,
                         d_wen, bus.cmd_ready);
    end
    tick;
    n_checks++;
    if ({bus.cmd_err, d_wen} !== 2'b00) begin
      n_fail++; $display("FAIL run_reject_after: got err=%b dwen=%b want 0/0", bus.cmd_err, d_wen);
    end
    send(3'd5, 12'h0, 8'd0, 32'h0);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({quit_cmd, running} !== 2'b11) begin
      n_fail++; $display("FAIL quit_pulse: got quit=%b run=%b want 1/1", quit_cmd, running);
    end
    tick;
    n_checks++;
    if ({quit_cmd, running, start_adr} !== {2'b00, 30'h40}) begin
      n_fail++; $display("FAIL quit_after: got quit=%b run=%b adr=%h want 0/0/40", quit_cmd,
                         running, start_adr);
    end
  endtask

  task automatic test_illegal_and_idle_quit;
    send(3'd7, 12'h044, 8'd0, 32'hFFFF_FFFF);
    tick;
    send(3'd5, 12'h0, 8'd0, 32'h0);
    n_checks++;
    if ({bus.cmd_err, i_wen, d_wen, i_sel, d_sel, bus.cmd_ready} !== 6'b100001) begin
      n_fail++; $display("FAIL illegal_op: got err=%b wen=%b%b sel=%b%b rdy=%b want 1 00 00 1",
                         bus.cmd_err, i_wen, d_wen, i_sel, d_sel, bus.cmd_ready);
    end
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({quit_cmd, running, bus.cmd_err} !== 3'b100) begin
      n_fail++; $display("FAIL idle_quit: got quit=%b run=%b err=%b want 1/0/0", quit_cmd,
                         running, bus.cmd_err);
    end
    tick;
  endtask

  task automatic test_reset_mid_burst;
    bit saw_rsp = 0;
    send(3'd3, 12'h050, 8'd3, 32'h0);
    bus.rsp_ready = 1'b1;
    tick;
    bus.cmd_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    n_checks++;
    if (any_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_immediate: got %b want 0", any_out);
    end
    tick;
    n_checks++;
    if (any_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_next: got %b want 0", any_out);
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (bus.rsp_valid || d_sel) saw_rsp = 1;
    end
    n_checks++;
    if ({saw_rsp, bus.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_release: got rsp_or_sel=%b rdy=%b want 0/1", saw_rsp,
                         bus.cmd_ready);
    end
  endtask

`ifdef RUN_WDOG_EN
  task automatic test_wdog;
    send(3'd4, 12'h0, 8'd0, 32'h0000_0200);
    tick;
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      n_checks++;
      if (quit_cmd !== (k == 16) || running !== 1'b1) begin
        n_fail++; $display("FAIL wdog_cycle_%0d: got quit=%b run=%b want %b/1", k, quit_cmd,
                           running, k == 16);
      end
    end
    tick;
    n_checks++;
    if ({quit_cmd, running} !== 2'b00) begin
      n_fail++; $display("FAIL wdog_after: got quit=%b run=%b want 0/0", quit_cmd, running);
    end
    send(3'd0, 12'h077, 8'd0, 32'h1234_5678);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({bus.cmd_err, i_wen} !== 2'b10) begin
      n_fail++; $display("FAIL wdog_sticky_err: got err=%b wen=%b want 1/0", bus.cmd_err, i_wen);
    end
    tick;
    send(3'd0, 12'h077, 8'd0, 32'h1234_5678);
    tick;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({bus.cmd_err, i_wen, i_wadr} !== {2'b01, 12'h077}) begin
      n_fail++; $display("FAIL wdog_err_cleared: got err=%b wen=%b adr=%h want 0/1/077",
                         bus.cmd_err, i_wen, i_wadr);
    end
    tick;
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_adr   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_i();
    test_back_to_back();
    test_rd_burst_d();
    test_rd_wrap_i();
    test_run_quit();
    test_illegal_and_idle_quit();
    test_reset_mid_burst();
`ifdef RUN_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
